lpc_mem_ctrl: RTL and testbench
===============================

LPC_MEM_CTRL -- requirements
Module: lpc_mem_ctrl

Interface
REQ-001 SHALL have parameter: DATA_W, 16, sample width in bits.
REQ-002 SHALL have parameter: WIN_LEN, 240, analysis window length in samples.
REQ-003 SHALL have parameter: FRAME_LEN, 80, new samples per frame.
REQ-004 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port: reset  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port: In_Done  input  1  write strobe; each cycle sampled high writes one sample.
REQ-007 SHALL have port: In_Sample  input  DATA_W  sample written when In_Done high.
REQ-008 SHALL have port: Out_Count  input  8  window read index; 0 = oldest, WIN_LEN-1 = newest.
REQ-009 SHALL have port: Out_Sample  output  DATA_W  registered window sample at Out_Count.
REQ-010 SHALL have port: frame_done  output  1  one-cycle pulse when a full frame of new samples is stored.

Function
REQ-011 SHALL store samples in a WIN_LEN x DATA_W circular buffer with write pointer wp (0..WIN_LEN-1), wrapping WIN_LEN-1 -> 0.
REQ-012 SHALL, on each rising edge with In_Done high, write In_Sample to mem[wp] and advance wp by 1; In_Done held high N cycles = N writes.
REQ-013 SHALL keep a frame counter fc (0..FRAME_LEN-1) incremented per write, wrapping FRAME_LEN-1 -> 0.
REQ-014 SHALL assert frame_done for exactly one cycle, in the cycle after the write that takes fc from FRAME_LEN-1 to 0; low otherwise.
REQ-015 SHALL register Out_Sample = mem[(wp + Out_Count) mod WIN_LEN] every cycle, with 1-cycle latency from Out_Count.
REQ-016 SHALL evaluate a read using pre-edge wp and memory contents when a write occurs on the same edge (read-before-write).
REQ-017 SHALL drive Out_Sample to 0 when Out_Count >= WIN_LEN.
REQ-018 SHALL keep a fill counter (0..WIN_LEN, saturating) incremented per write.

Reset
REQ-019 SHALL, while reset is low, force wp=0, fc=0, fill=0, frame_done=0, Out_Sample=0, independent of clock.
REQ-020 SHALL NOT require memory array clearing on reset; a write coinciding with reset release is ignored.
REQ-021 SHALL, on reset asserted mid-frame, discard the partial frame; no frame_done is produced for it.

Configuration
REQ-022 SHALL implement zero-fill when macro LPC_MEM_CTRL_ZERO_FILL_EN is defined: window index i returns 0 while i < WIN_LEN - fill (position not yet written since reset).
REQ-023 SHALL, without LPC_MEM_CTRL_ZERO_FILL_EN, return raw memory contents for all in-range indices; the fill counter is omitted and unwritten positions are unspecified.

Verification
REQ-024 SHALL verify: reset low, then 80 writes of values 1..80 -> frame_done high exactly one cycle after 80th write; no pulse earlier.
REQ-025 SHALL verify: after 240 writes of values 1..240 -> Out_Count=0 reads 1, Out_Count=239 reads 240 (next cycle), frame_done pulsed 3 times.
REQ-026 SHALL verify: 260 writes of values 1..260 -> Out_Count=0 reads 21, Out_Count=239 reads 260 (wrap-around).
REQ-027 SHALL verify: with ZERO_FILL_EN, 80 writes of values 1..80 -> Out_Count=159 reads 0, Out_Count=160 reads 1, Out_Count=239 reads 80; Out_Count=250 reads 0.
REQ-028 SHALL verify: 40 writes, reset pulsed low, then 80 writes -> single frame_done only after 80th post-reset write; Out_Sample 0 during reset.
REQ-029 SHALL verify: write with Out_Count=239 on same edge -> Out_Sample shows previous newest sample; next cycle shows new sample.

Source files
------------

// File: rtl/lpc_mem_ctrl.sv
// Circular sample window for LPC analysis: stores incoming samples, pulses once per frame,
// serves a registered oldest-to-newest window read. Optional zero-fill: LPC_MEM_CTRL_ZERO_FILL_EN.
module lpc_mem_ctrl #(
   parameter int DATA_W    = 16,
   parameter int WIN_LEN   = 240,
   parameter int FRAME_LEN = 80
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              In_Done,
   input  logic [DATA_W-1:0] In_Sample,
   input  logic [7:0]        Out_Count,
   output logic [DATA_W-1:0] Out_Sample,
   output logic              frame_done
);

   localparam int WP_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int FC_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int IDX_W = $clog2(WIN_LEN + 256);
   localparam logic [IDX_W-1:0] WIN_X = IDX_W'(WIN_LEN);

   logic [DATA_W-1:0] mem [WIN_LEN];

   logic [WP_W-1:0]   wp_q, wp_d;
   logic [FC_W-1:0]   fc_q, fc_d;
   logic              frame_q, frame_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [IDX_W-1:0]  oc_ext, sum, rd_addr;

`ifdef LPC_MEM_CTRL_ZERO_FILL_EN
   localparam int FILL_W = $clog2(WIN_LEN + 1);
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [IDX_W-1:0]  unfilled;
`endif

   always_comb begin
      wp_d    = wp_q;
      fc_d    = fc_q;
      frame_d = 1'b0;
      if (In_Done) begin
         wp_d = (wp_q == WP_W'(WIN_LEN - 1)) ? '0 : wp_q + WP_W'(1);
         if (fc_q == FC_W'(FRAME_LEN - 1)) begin
            fc_d    = '0;
            frame_d = 1'b1;
         end else begin
            fc_d = fc_q + FC_W'(1);
         end
      end
   end

   // Window index 0 is the slot about to be overwritten, i.e. the oldest sample.
   always_comb begin
      oc_ext  = IDX_W'(Out_Count);
      sum     = IDX_W'(wp_q) + oc_ext;
      rd_addr = (sum >= WIN_X) ? sum - WIN_X : sum;
      out_d   = '0;
      if (oc_ext < WIN_X) begin
         out_d = mem[rd_addr[WP_W-1:0]];
      end
`ifdef LPC_MEM_CTRL_ZERO_FILL_EN
      unfilled = WIN_X - IDX_W'(fill_q);
      if (oc_ext < unfilled) begin
         out_d = '0;
      end
`endif
   end

`ifdef LPC_MEM_CTRL_ZERO_FILL_EN
   always_comb begin
      fill_d = fill_q;
      if (In_Done && (fill_q != FILL_W'(WIN_LEN))) begin
         fill_d = fill_q + FILL_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wp_q    <= '0;
         fc_q    <= '0;
         frame_q <= 1'b0;
         out_q   <= '0;
      end else begin
         wp_q    <= wp_d;
         fc_q    <= fc_d;
         frame_q <= frame_d;
         out_q   <= out_d;
      end
   end

   // Array is not reset; the read above sees pre-edge contents on a same-edge write.
   always_ff @(posedge clock) begin
      if (In_Done) begin
         mem[wp_q] <= In_Sample;
      end
   end

   assign Out_Sample = out_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_lpc_mem_ctrl.sv
// Directed bench for lpc_mem_ctrl: frame pulses, window reads, wrap-around, reset mid-frame.
module tb_lpc_mem_ctrl;

   localparam int DATA_W    = 16;
   localparam int WIN_LEN   = 240;
   localparam int FRAME_LEN = 80;

   logic              clock;
   logic              reset;
   logic              In_Done;
   logic [DATA_W-1:0] In_Sample;
   logic [7:0]        Out_Count;
   logic [DATA_W-1:0] Out_Sample;
   logic              frame_done;

   int n_chk;
   int n_err;
   int nwr;
   int pulses;

   lpc_mem_ctrl #(
      .DATA_W   (DATA_W),
      .WIN_LEN  (WIN_LEN),
      .FRAME_LEN(FRAME_LEN)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .In_Done   (In_Done),
      .In_Sample (In_Sample),
      .Out_Count (Out_Count),
      .Out_Sample(Out_Sample),
      .frame_done(frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One write per call; frame_done must be high only after every FRAME_LEN-th write since reset.
   task automatic wr(input int v);
      In_Done   = 1'b1;
      In_Sample = DATA_W'(v);
      @(posedge clock);
      #1;
      In_Done = 1'b0;
      nwr++;
      pulses += int'(frame_done);
      chk("frame_done_wr", {31'b0, frame_done}, {31'b0, (nwr % FRAME_LEN) == 0});
   endtask

   task automatic rd(input int idx, input int exp);
      Out_Count = 8'(idx);
      @(posedge clock);
      #1;
      chk($sformatf("read_idx%0d", idx), {16'b0, Out_Sample}, exp);
      chk("frame_done_idle", {31'b0, frame_done}, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      chk("rst_out_async", {16'b0, Out_Sample}, 32'd0);
      chk("rst_fd_async", {31'b0, frame_done}, 32'd0);
      @(posedge clock);
      #1;
      chk("rst_out_held", {16'b0, Out_Sample}, 32'd0);
      reset = 1'b1;
      nwr   = 0;
   endtask

   initial begin
      n_chk     = 0;
      n_err     = 0;
      nwr       = 0;
      pulses    = 0;
      reset     = 1'b0;
      In_Done   = 1'b0;
      In_Sample = '0;
      Out_Count = 8'd0;
      do_reset();

      // First frame: exactly one pulse, right after the 80th write.
      for (int v = 1; v <= 80; v++) wr(v);
      chk("pulses_80", pulses, 1);
`ifdef LPC_MEM_CTRL_ZERO_FILL_EN
      rd(159, 0);
`endif
      rd(160, 1);
      rd(239, 80);
      rd(250, 0);

      // Full window.
      for (int v = 81; v <= 240; v++) wr(v);
      chk("pulses_240", pulses, 3);
      rd(0, 1);
      rd(239, 240);
      rd(120, 121);

      // Wrap-around.
      for (int v = 241; v <= 260; v++) wr(v);
      rd(0, 21);
      rd(239, 260);
      rd(255, 0);

      // Same-edge write and read of the newest slot.
      Out_Count = 8'd239;
      wr(261);
      chk("rbw_old", {16'b0, Out_Sample}, 32'd260);
      rd(239, 261);

      // Partial frame aborted by reset.
      do_reset();
      pulses = 0;
      for (int v = 1001; v <= 1040; v++) wr(v);
      Out_Count = 8'd239;
      #1;
      do_reset();
      for (int v = 1; v <= 80; v++) wr(v);
      chk("pulses_post_rst", pulses, 1);
      rd(239, 80);
      rd(238, 79);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
